// File: rtl/sha256_multiblock_hash.sv
// sha256_multiblock_hash
//   SHA-256 of a fixed-length message of MSG_BYTES bytes. The message is padded
//   internally and hashed block by block through an iterative compression core
//   (sha256_core, below). A caller-supplied chaining value plus PREFIX_BYTES of
//   already-absorbed data allow HMAC inner/outer hashes from precomputed
//   ipad/opad states.
//
//   Parameters
//     MSG_BYTES     message length in bytes (>=1); byte 0 = data[MSG_BYTES*8-1 -: 8]
//     PREFIX_BYTES  bytes already absorbed into iv (multiple of 64); only the
//                   length field sees them
//
//   Ports
//     clk, n_rst   clock, asynchronous active-low reset
//     start        1-cycle request, sampled only while idle
//     abort        synchronous cancel back to idle (wins over start)
//     data         message, latched on accepted start
//     use_iv, iv   1: chain from iv, 0: standard H0; latched on accepted start
//     hash         registered digest, held until the next completed hash
//     busy         high from the cycle after an accepted start until DONE exits
//     hash_done    1-cycle pulse, hash valid in the same cycle
//
//   Handshake: start is a single-cycle request with no ready; a start seen
//   while busy is dropped, never queued.
//
//   Timing: the core raises hash_done 66 cycles after its first enabled cycle,
//   so each block holds the core enabled for 67 cycles (including the cycle in
//   which the wrapper sees hash_done). Blocks are separated by one GAP cycle,
//   giving start -> hash_done = 1 + 67*NBLK + (NBLK-1) cycles.

// sha256_core
//   One SHA-256 compression per enable interval. Dropping enable clears the
//   round counter, so a new block starts cleanly on the next rising enable.
//   Ports: enable (hold high for the whole block), data (512-bit block),
//   current_hash (chaining input), hash (registered result), hash_done (pulse).
module sha256_core (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         enable,
    input  logic [511:0] data,
    input  logic [255:0] current_hash,
    output logic [255:0] hash,
    output logic         hash_done
);
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // cnt: 0 = load, 1..64 = round cnt-1, 65 = finalize, 66 = hold
    logic [6:0]   cnt_q, cnt_d;
    logic [31:0]  v_q [8];
    logic [31:0]  v_d [8];
    logic [31:0]  w_q [16];
    logic [31:0]  w_d [16];
    logic [255:0] hash_q, hash_d;
    logic         done_q, done_d;
    logic [31:0]  t1, t2, w_new;
    logic [5:0]   rnd;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    always_comb begin
        rnd   = 6'(cnt_q - 7'd1);
        t1    = v_q[7] + (rotr(v_q[4], 6) ^ rotr(v_q[4], 11) ^ rotr(v_q[4], 25))
              + ((v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6])) + K[rnd] + w_q[0];
        t2    = (rotr(v_q[0], 2) ^ rotr(v_q[0], 13) ^ rotr(v_q[0], 22))
              + ((v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2]) ^ (v_q[1] & v_q[2]));
        // 16-word sliding window: w_q[0] is W[t], w_new is W[t+16]
        w_new = (rotr(w_q[14], 17) ^ rotr(w_q[14], 19) ^ (w_q[14] >> 10)) + w_q[9]
              + (rotr(w_q[1], 7) ^ rotr(w_q[1], 18) ^ (w_q[1] >> 3)) + w_q[0];
    end

    always_comb begin
        cnt_d  = cnt_q;
        v_d    = v_q;
        w_d    = w_q;
        hash_d = hash_q;
        done_d = 1'b0;
        if (!enable) begin
            cnt_d = '0;
        end else if (cnt_q == 7'd0) begin
            for (int i = 0; i < 8; i++)  v_d[i] = current_hash[255-32*i -: 32];
            for (int i = 0; i < 16; i++) w_d[i] = data[511-32*i -: 32];
            cnt_d = 7'd1;
        end else if (cnt_q <= 7'd64) begin
            v_d[0] = t1 + t2;
            v_d[1] = v_q[0];
            v_d[2] = v_q[1];
            v_d[3] = v_q[2];
            v_d[4] = v_q[3] + t1;
            v_d[5] = v_q[4];
            v_d[6] = v_q[5];
            v_d[7] = v_q[6];
            for (int i = 0; i < 15; i++) w_d[i] = w_q[i+1];
            w_d[15] = w_new;
            cnt_d   = cnt_q + 7'd1;
        end else if (cnt_q == 7'd65) begin
            for (int i = 0; i < 8; i++) hash_d[255-32*i -: 32] = current_hash[255-32*i -: 32] + v_q[i];
            done_d = 1'b1;
            cnt_d  = 7'd66;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q  <= '0;
            hash_q <= '0;
            done_q <= 1'b0;
            for (int i = 0; i < 8; i++)  v_q[i] <= '0;
            for (int i = 0; i < 16; i++) w_q[i] <= '0;
        end else begin
            cnt_q  <= cnt_d;
            v_q    <= v_d;
            w_q    <= w_d;
            hash_q <= hash_d;
            done_q <= done_d;
        end
    end

    assign hash      = hash_q;
    assign hash_done = done_q;
endmodule

module sha256_multiblock_hash #(
    parameter int MSG_BYTES    = 80,
    parameter int PREFIX_BYTES = 0
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [MSG_BYTES*8-1:0] data,
    input  logic                   use_iv,
    input  logic [255:0]           iv,
    output logic [255:0]           hash,
    output logic                   busy,
    output logic                   hash_done
);
    localparam int NBLK     = (MSG_BYTES + 9 + 63) / 64;
    localparam int MSG_BITS = MSG_BYTES * 8;
    localparam int PAD_BITS = NBLK * 512;
    localparam int BLK_W    = (NBLK > 1) ? $clog2(NBLK) : 1;
    localparam logic [63:0]  LEN_BITS = 64'((PREFIX_BYTES + MSG_BYTES) * 8);
    localparam logic [255:0] H0 =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;
    logic [255:0]    chain_q, chain_d;
    logic [255:0]    hash_q, hash_d;
    logic [MSG_BITS-1:0] data_q, data_d;

    logic [PAD_BITS-1:0] padded;
    logic [511:0]        core_data;
    logic [255:0]        core_hash;
    logic                core_en, core_done, last_blk;

    // Padded message is rebuilt from the latched data every cycle; when
    // MSG_BYTES%64==55 the 0x80 byte lands directly above the length field.
    always_comb begin
        padded = '0;
        padded[PAD_BITS-1 -: MSG_BITS]   = data_q;
        padded[PAD_BITS-MSG_BITS-1 -: 8] = 8'h80;
        padded[63:0]                     = LEN_BITS;
        core_data = '0;
        for (int k = 0; k < NBLK; k++) begin
            if (blk_cnt_q == BLK_W'(k)) core_data = padded[PAD_BITS-1-512*k -: 512];
        end
    end

    assign last_blk = (blk_cnt_q == BLK_W'(NBLK - 1));

    sha256_core u_core (
        .clk          (clk),
        .n_rst        (n_rst),
        .enable       (core_en),
        .data         (core_data),
        .current_hash (chain_q),
        .hash         (core_hash),
        .hash_done    (core_done)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= S_IDLE;
            blk_cnt_q <= '0;
            chain_q   <= '0;
            hash_q    <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            blk_cnt_q <= blk_cnt_d;
            chain_q   <= chain_d;
            hash_q    <= hash_d;
            data_q    <= data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        blk_cnt_d = blk_cnt_q;
        chain_d   = chain_q;
        hash_d    = hash_q;
        data_d    = data_q;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    data_d    = data;
                    chain_d   = use_iv ? iv : H0;
                    blk_cnt_d = '0;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (core_done) begin
                    chain_d = core_hash;
                    if (last_blk) begin
                        hash_d  = core_hash;
                        state_d = S_DONE;
                    end else begin
                        blk_cnt_d = blk_cnt_q + BLK_W'(1);
                        state_d   = S_GAP;
                    end
                end
            end
            // one cycle with the core disabled so it restarts from its load step
            S_GAP:   state_d = abort ? S_IDLE : S_RUN;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        core_en   = 1'b0;
        busy      = 1'b0;
        hash_done = 1'b0;
        case (state_q)
            S_RUN: begin
                core_en = 1'b1;
                busy    = 1'b1;
            end
            S_GAP:  busy = 1'b1;
            S_DONE: begin
                busy      = 1'b1;
                hash_done = 1'b1;
            end
            default: ;
        endcase
    end

    assign hash = hash_q;
endmodule

// File: tb/tb_sha256_multiblock_hash.sv
module tb_sha256_multiblock_hash;
    localparam int NU = 7;
    localparam logic [255:0] H0 =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] EXP_ABC =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] EXP_TWO =
        256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    // RFC 4231 case 2: HMAC-SHA256(key "Jefe", "what do ya want for nothing?")
    localparam logic [255:0] EXP_HMAC =
        256'h5bdcc146bf60754e6a042426089575c75a003f089d2739839dec58b964ec3843;
    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef struct {
        logic         use_iv;
        logic [255:0] iv;
        logic [255:0] exp;
        int           lat;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk;
    logic n_rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT instances ----------------
    logic         st  [NU];
    logic         ab  [NU];
    logic         uiv [NU];
    logic [255:0] ivv [NU];
    logic [255:0] hs  [NU];
    logic         bz  [NU];
    logic         hd  [NU];
    logic [23:0]  d_abc;
    logic [447:0] d_two;
    logic [223:0] d_hin;
    logic [255:0] d_hout;
    logic [639:0] d_h80;
    logic [439:0] d_r55;
    logic [511:0] d_r64;

    sha256_multiblock_hash #(.MSG_BYTES(3), .PREFIX_BYTES(0)) u_abc (
        .clk(clk), .n_rst(n_rst), .start(st[0]), .abort(ab[0]), .data(d_abc), .use_iv(uiv[0]),
        .iv(ivv[0]), .hash(hs[0]), .busy(bz[0]), .hash_done(hd[0]));
    sha256_multiblock_hash #(.MSG_BYTES(56), .PREFIX_BYTES(0)) u_two (
        .clk(clk), .n_rst(n_rst), .start(st[1]), .abort(ab[1]), .data(d_two), .use_iv(uiv[1]),
        .iv(ivv[1]), .hash(hs[1]), .busy(bz[1]), .hash_done(hd[1]));
    sha256_multiblock_hash #(.MSG_BYTES(28), .PREFIX_BYTES(64)) u_hin (
        .clk(clk), .n_rst(n_rst), .start(st[2]), .abort(ab[2]), .data(d_hin), .use_iv(uiv[2]),
        .iv(ivv[2]), .hash(hs[2]), .busy(bz[2]), .hash_done(hd[2]));
    sha256_multiblock_hash #(.MSG_BYTES(32), .PREFIX_BYTES(64)) u_hout (
        .clk(clk), .n_rst(n_rst), .start(st[3]), .abort(ab[3]), .data(d_hout), .use_iv(uiv[3]),
        .iv(ivv[3]), .hash(hs[3]), .busy(bz[3]), .hash_done(hd[3]));
    sha256_multiblock_hash #(.MSG_BYTES(80), .PREFIX_BYTES(64)) u_h80 (
        .clk(clk), .n_rst(n_rst), .start(st[4]), .abort(ab[4]), .data(d_h80), .use_iv(uiv[4]),
        .iv(ivv[4]), .hash(hs[4]), .busy(bz[4]), .hash_done(hd[4]));
    sha256_multiblock_hash #(.MSG_BYTES(55), .PREFIX_BYTES(0)) u_r55 (
        .clk(clk), .n_rst(n_rst), .start(st[5]), .abort(ab[5]), .data(d_r55), .use_iv(uiv[5]),
        .iv(ivv[5]), .hash(hs[5]), .busy(bz[5]), .hash_done(hd[5]));
    sha256_multiblock_hash #(.MSG_BYTES(64), .PREFIX_BYTES(0)) u_r64 (
        .clk(clk), .n_rst(n_rst), .start(st[6]), .abort(ab[6]), .data(d_r64), .use_iv(uiv[6]),
        .iv(ivv[6]), .hash(hs[6]), .busy(bz[6]), .hash_done(hd[6]));

    // ---------------- reference model ----------------
    logic [7:0] mbuf [128];

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0]  w [64];
        logic [31:0]  v [8];
        logic [31:0]  t1, t2;
        logic [255:0] hout;
        for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 64; t++)
            w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                 + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
        for (int i = 0; i < 8; i++) v[i] = hin[255-32*i -: 32];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
            t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
            v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) hout[255-32*i -: 32] = hin[255-32*i -: 32] + v[i];
        return hout;
    endfunction

    // hashes mbuf[0..len-1] continuing from h_init with prefix bytes already absorbed
    function automatic logic [255:0] sha_model(input logic [255:0] h_init, input int len, input int prefix);
        logic [7:0]   pb [192];
        logic [511:0] blk;
        logic [255:0] h;
        logic [63:0]  bits;
        int           nblk;
        nblk = (len + 72) / 64;
        for (int i = 0; i < 192; i++) pb[i] = 8'h00;
        for (int i = 0; i < len; i++) pb[i] = mbuf[i];
        pb[len] = 8'h80;
        bits = 64'((prefix + len) * 8);
        for (int i = 0; i < 8; i++) pb[nblk*64-8+i] = bits[63-8*i -: 8];
        h = h_init;
        for (int k = 0; k < nblk; k++) begin
            for (int i = 0; i < 64; i++) blk[511-8*i -: 8] = pb[64*k+i];
            h = compress(h, blk);
        end
        return h;
    endfunction

    function automatic int exp_lat(input int len);
        int nb;
        nb = (len + 72) / 64;
        return 1 + 67 * nb + (nb - 1);
    endfunction

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check256(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic run_vec(input int u, output logic [255:0] got, output int lat, output int pulses);
        @(negedge clk);
        st[u] = 1'b1;
        @(negedge clk);
        st[u] = 1'b0;
        check_int($sformatf("unit%0d busy after start", u), int'(bz[u]), 1);
        lat = -1;
        pulses = 0;
        got = '0;
        for (int k = 1; k < 400; k++) begin
            if (hd[u]) begin
                pulses++;
                if (lat < 0) begin
                    lat = k;
                    got = hs[u];
                end
            end
            if (lat >= 0 && k >= lat + 3) break;
            @(negedge clk);
        end
        if (lat < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unit%0d timeout: no hash_done within 400 cycles", u);
        end
    endtask

    // ---------------- test ----------------
    vec_t         vt [NU];
    string        vname [NU];
    logic [255:0] got, iv_in, iv_out, inner;
    logic [511:0] kblk, ipad_blk, opad_blk;
    int           lat, pulses;

    initial begin
        n_rst = 1'b0;
        for (int u = 0; u < NU; u++) begin
            st[u] = 1'b0; ab[u] = 1'b0; uiv[u] = 1'b0; ivv[u] = '0;
        end
        d_abc = "abc";
        d_two = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
        d_hin = "what do ya want for nothing?";

        // HMAC key "Jefe": precomputed ipad / opad chaining states
        kblk = '0;
        kblk[511 -: 32] = 32'h4a656665;
        for (int i = 0; i < 64; i++) begin
            ipad_blk[511-8*i -: 8] = kblk[511-8*i -: 8] ^ 8'h36;
            opad_blk[511-8*i -: 8] = kblk[511-8*i -: 8] ^ 8'h5c;
        end
        iv_in  = compress(H0, ipad_blk);
        iv_out = compress(H0, opad_blk);
        for (int i = 0; i < 28; i++) mbuf[i] = d_hin[223-8*i -: 8];
        inner  = sha_model(iv_in, 28, 64);
        d_hout = inner;
        for (int i = 0; i < 80; i++) begin
            mbuf[i] = 8'(i * 7 + 3);
            d_h80[639-8*i -: 8] = mbuf[i];
        end
        vt[4] = '{1'b1, iv_in, sha_model(iv_in, 80, 64), exp_lat(80)};
        for (int i = 0; i < 55; i++) begin
            mbuf[i] = 8'($urandom_range(0, 255));
            d_r55[439-8*i -: 8] = mbuf[i];
        end
        vt[5] = '{1'b0, 256'hdeadbeef, sha_model(H0, 55, 0), exp_lat(55)};
        for (int i = 0; i < 64; i++) begin
            mbuf[i] = 8'($urandom_range(0, 255));
            d_r64[511-8*i -: 8] = mbuf[i];
        end
        vt[6] = '{1'b0, 256'hcafef00d, sha_model(H0, 64, 0), exp_lat(64)};
        vt[0] = '{1'b0, {8{32'h5a5a5a5a}}, EXP_ABC, exp_lat(3)};
        vt[1] = '{1'b0, '0, EXP_TWO, exp_lat(56)};
        vt[2] = '{1'b1, iv_in, inner, exp_lat(28)};
        vt[3] = '{1'b1, iv_out, EXP_HMAC, exp_lat(32)};
        vname = '{"abc", "two_block", "hmac_inner", "hmac_outer", "hmac_inner80", "rand55", "rand64"};

        // reset values
        repeat (3) @(negedge clk);
        for (int u = 0; u < NU; u++) begin
            check256($sformatf("%s reset hash", vname[u]), hs[u], '0);
            check_int($sformatf("%s reset busy/done", vname[u]), int'({bz[u], hd[u]}), 0);
        end
        n_rst = 1'b1;

        // table-driven vectors
        for (int v = 0; v < NU; v++) begin
            uiv[v] = vt[v].use_iv;
            ivv[v] = vt[v].iv;
            run_vec(v, got, lat, pulses);
            check256({vname[v], " digest"}, got, vt[v].exp);
            check_int({vname[v], " latency"}, lat, vt[v].lat);
            check_int({vname[v], " pulses"}, pulses, 1);
            check256({vname[v], " hash held"}, hs[v], vt[v].exp);
            check_int({vname[v], " busy after done"}, int'(bz[v]), 0);
        end

        // abort 5 cycles into block 1 of the two-block unit
        d_two = {56{8'h5a}};
        @(negedge clk); st[1] = 1'b1;
        @(negedge clk); st[1] = 1'b0;
        repeat (73) @(negedge clk);
        check_int("abort busy before", int'(bz[1]), 1);
        ab[1] = 1'b1;
        @(negedge clk);
        ab[1] = 1'b0;
        check_int("abort busy next cycle", int'(bz[1]), 0);
        pulses = 0;
        for (int k = 0; k < 150; k++) begin
            if (hd[1]) pulses++;
            @(negedge clk);
        end
        check_int("abort no hash_done", pulses, 0);
        check256("abort hash unchanged", hs[1], EXP_TWO);
        d_two = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
        run_vec(1, got, lat, pulses);
        check256("after abort digest", got, EXP_TWO);
        check_int("after abort latency", lat, exp_lat(56));

        // start while busy is ignored; data changes after latch have no effect
        @(negedge clk); st[0] = 1'b1;
        @(negedge clk); st[0] = 1'b0;
        repeat (19) @(negedge clk);
        d_abc = "xyz";
        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        lat = -1;
        pulses = 0;
        got = '0;
        for (int k = 21; k < 200; k++) begin
            if (hd[0]) begin
                pulses++;
                if (lat < 0) begin
                    lat = k;
                    got = hs[0];
                end
            end
            @(negedge clk);
        end
        check256("busy start ignored digest", got, EXP_ABC);
        check_int("busy start ignored latency", lat, exp_lat(3));
        check_int("busy start ignored pulses", pulses, 1);

        // reset mid-RUN, then a fresh "abc"
        d_abc = "abc";
        @(negedge clk); st[0] = 1'b1;
        @(negedge clk); st[0] = 1'b0;
        repeat (29) @(negedge clk);
        n_rst = 1'b0;
        @(negedge clk);
        check256("mid-run reset hash", hs[0], '0);
        check_int("mid-run reset busy/done", int'({bz[0], hd[0]}), 0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        run_vec(0, got, lat, pulses);
        check256("after reset digest", got, EXP_ABC);
        check_int("after reset pulses", pulses, 1);

        // abort and start together in IDLE: abort wins
        @(negedge clk);
        st[0] = 1'b1;
        ab[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        ab[0] = 1'b0;
        check_int("abort+start busy", int'(bz[0]), 0);
        @(negedge clk);
        check_int("abort+start busy later", int'({bz[0], hd[0]}), 0);
        check256("abort+start hash kept", hs[0], EXP_ABC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
